// File: rtl/fifo_level.sv
// Show-ahead ready/valid FIFO with occupancy count, almost flags,
// synchronous flush and a clearable high-water monitor.
module fifo_level #(
  parameter int DEPTH_LOG2_P   = 3,
  parameter int WIDTH_P        = 8,
  parameter int ALMOST_FULL_P  = 6,
  parameter int ALMOST_EMPTY_P = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [WIDTH_P-1:0]      data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [WIDTH_P-1:0]      data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  input  logic                    flush_i,
  output logic [DEPTH_LOG2_P:0]   count_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic [DEPTH_LOG2_P:0]   peak_o,
  input  logic                    clr_peak_i
);

  localparam int AW    = DEPTH_LOG2_P;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW:0] AF_C = (AW+1)'(ALMOST_FULL_P);
  localparam logic [AW:0] AE_C = (AW+1)'(ALMOST_EMPTY_P);

  logic [WIDTH_P-1:0] r_mem [DEPTH];
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [AW:0]        r_count;
  logic [AW:0]        r_peak;

  logic               w_full;
  logic               w_empty;
  logic               w_wr;
  logic               w_rd;
  logic [AW:0]        w_wr_nxt;
  logic [AW:0]        w_rd_nxt;
  logic [AW:0]        w_cnt_nxt;

  // Extra wrap bit distinguishes full from empty when low bits match.
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign ready_o = ~w_full & ~flush_i;
  assign valid_o = ~w_empty & ~flush_i;

  assign w_wr = valid_i & ready_o;
  assign w_rd = valid_o & ready_i;

  assign w_wr_nxt  = r_wr_ptr + {{AW{1'b0}}, w_wr};
  assign w_rd_nxt  = r_rd_ptr + {{AW{1'b0}}, w_rd};
  assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;

  assign data_o         = r_mem[r_rd_ptr[AW-1:0]];
  assign count_o        = r_count;
  assign peak_o         = r_peak;
  assign almost_full_o  = (r_count >= AF_C);
  assign almost_empty_o = (r_count <= AE_C);

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_peak   <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_peak   <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      if (clr_peak_i) begin
        r_peak <= w_cnt_nxt;
      end else if (w_cnt_nxt > r_peak) begin
        r_peak <= w_cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_level.sv
// Randomized and directed bench for fifo_level against a queue-based
// reference model of the occupancy, flags and peak monitor.
module tb_fifo_level;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       flush_i;
  logic [3:0] count_o;
  logic       almost_full_o;
  logic       almost_empty_o;
  logic [3:0] peak_o;
  logic       clr_peak_i;

  fifo_level #(
    .DEPTH_LOG2_P  (3),
    .WIDTH_P       (8),
    .ALMOST_FULL_P (6),
    .ALMOST_EMPTY_P(1)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .flush_i       (flush_i),
    .count_o       (count_o),
    .almost_full_o (almost_full_o),
    .almost_empty_o(almost_empty_o),
    .peak_o        (peak_o),
    .clr_peak_i    (clr_peak_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_q[$];
  int         m_peak = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Called at posedge+1; applies inputs for one cycle and checks both
  // the pre-edge handshake view and the post-edge registered state.
  task automatic step(input logic vi, input logic [7:0] d,
                      input logic ri, input logic fl, input logic cp);
    bit m_rdy, m_vld;
    valid_i    = vi;
    data_i     = d;
    ready_i    = ri;
    flush_i    = fl;
    clr_peak_i = cp;
    #1;
    m_rdy = (m_q.size() < 8) && !fl;
    m_vld = (m_q.size() > 0) && !fl;
    chk("ready_o", int'(ready_o), int'(m_rdy));
    chk("valid_o", int'(valid_o), int'(m_vld));
    if (m_vld) chk("data_o", int'(data_o), int'(m_q[0]));
    @(posedge clk_i);
    #1;
    if (fl) begin
      m_q.delete();
      m_peak = 0;
    end else begin
      if (m_vld && ri) void'(m_q.pop_front());
      if (m_rdy && vi) m_q.push_back(d);
      if (cp) m_peak = m_q.size();
      else if (m_q.size() > m_peak) m_peak = m_q.size();
    end
    chk("count_o", int'(count_o), m_q.size());
    chk("peak_o", int'(peak_o), m_peak);
    chk("almost_full_o", int'(almost_full_o), int'(m_q.size() >= 6));
    chk("almost_empty_o", int'(almost_empty_o), int'(m_q.size() <= 1));
  endtask

  task automatic chk_reset_outs();
    chk("rst valid_o", int'(valid_o), 0);
    chk("rst ready_o", int'(ready_o), 1);
    chk("rst count_o", int'(count_o), 0);
    chk("rst peak_o", int'(peak_o), 0);
    chk("rst almost_empty_o", int'(almost_empty_o), 1);
    chk("rst almost_full_o", int'(almost_full_o), 0);
  endtask

  initial begin
    rst_i      = 1'b1;
    data_i     = '0;
    valid_i    = 1'b0;
    ready_i    = 1'b0;
    flush_i    = 1'b0;
    clr_peak_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_outs();
    rst_i = 1'b0;

    // Asynchronous reset mid-cycle with three words stored
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_outs();
    m_q.delete();
    m_peak = 0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Fill to full
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      chk("fill count", int'(count_o), i + 1);
      chk("fill af", int'(almost_full_o), int'(i + 1 >= 6));
      chk("fill ae", int'(almost_empty_o), int'(i + 1 <= 1));
    end
    chk("full ready_o", int'(ready_o), 0);
    chk("full peak", int'(peak_o), 8);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("9th rejected", int'(count_o), 8);

    // Drain in order
    for (int i = 0; i < 8; i++) begin
      chk("drain data", int'(data_o), 8'h10 + i);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drained valid_o", int'(valid_o), 0);
    chk("drained count", int'(count_o), 0);
    chk("drained peak", int'(peak_o), 8);

    // Simultaneous read/write at full, then steady-state wrap
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h28, 1'b1, 1'b0, 1'b0);
    chk("full rw count", int'(count_o), 7);
    step(1'b1, 8'h28, 1'b0, 1'b0, 1'b0);
    chk("refill count", int'(count_o), 8);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
    while (m_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    chk("flush count", int'(count_o), 0);
    chk("flush peak", int'(peak_o), 0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("post-flush valid", int'(valid_o), 1);
    chk("post-flush data", int'(data_o), 8'hAA);

    // Peak clear
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("pre-clr peak", int'(peak_o), 8);
    chk("pre-clr count", int'(count_o), 3);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr peak", int'(peak_o), 3);
    step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    chk("peak after 2", int'(peak_o), 5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60),
           8'($urandom),
           1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 99) < 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
